conv_window_ctrl: RTL and testbench
===================================

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter IMG_W, default 32, meaning image width in pixels (3..2047).
REQ-002 Parameter IMG_H, default 32, meaning image height in rows (3..2047); IMG_W*IMG_H SHALL be at most 2048.
REQ-003 Parameter ADDR_W, default 11, meaning width of the pixel read address.
REQ-004 clk  in  1  sole clock; all state SHALL change on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle frame start request.
REQ-007 rd_addr  out  ADDR_W  pixel read address into the image register file, whose read is combinational.
REQ-008 push_pixel  out  1  shifts the pixel currently at rd_addr into the 3-stage pixelBuf chain at this edge.
REQ-009 win_valid  out  1  the 3x3 window registers hold a complete in-image window.
REQ-010 win_ready  in  1  downstream accepts the window this cycle.
REQ-011 out_addr  out  ADDR_W  linear index of the current window, (row-2)*(IMG_W-2)+(col-2).
REQ-012 busy  out  1  a frame is in progress.
REQ-013 done  out  1  one-cycle pulse at frame end.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-015 In IDLE with start=1, the FSM SHALL go to RUN next cycle with rd_addr=0; busy SHALL be 1 in RUN, DRAIN and DONE.
REQ-016 In RUN, push_pixel SHALL be 1 unless stalled; each push SHALL advance rd_addr by 1 and the internal col (wrapping at IMG_W-1 to 0) and row counters.
REQ-017 Stalled SHALL mean win_valid=1 and win_ready=0; while stalled, push_pixel, rd_addr, col, row, out_addr and win_valid SHALL hold.
REQ-018 After a push of pixel (row,col) with row>=2 and col>=2, win_valid SHALL be 1 in the next cycle, with the matching out_addr; otherwise win_valid SHALL drop after acceptance.
REQ-019 Windows straddling a row wrap (col<2) SHALL never assert win_valid.
REQ-020 A push and the acceptance of the previous window SHALL be allowed in the same cycle, giving one window per cycle at full throughput.
REQ-021 On the push of address IMG_W*IMG_H-1, the FSM SHALL go to DRAIN; DRAIN SHALL go to DONE once the final window is accepted.
REQ-022 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 out_addr SHALL increment by 1 per accepted window, starting at 0, with a final value of (IMG_W-2)*(IMG_H-2)-1.

Reset
REQ-025 While reset=0, the state SHALL be IDLE, and rd_addr, out_addr, row and col SHALL be 0.
REQ-026 While reset=0, push_pixel, win_valid, busy and done SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no done pulse.
REQ-028 Deassertion of reset SHALL be synchronised to clk via a 2-flop release.

Configuration
REQ-029 With CONV_WINDOW_CTRL_ABORT_EN defined, an input abort (1 bit) SHALL exist.
REQ-030 With that macro, abort=1 in RUN or DRAIN SHALL force IDLE next cycle, clear win_valid and pulse done without a final window.
REQ-031 Without the macro, the abort port and its logic SHALL be absent.

Structure
REQ-032 Package conv_pkg SHALL hold the FSM state enum, the default IMG_W and IMG_H values, and the window-count function (IMG_W-2)*(IMG_H-2).
REQ-033 One sub-module, conv_pos_counter (the col/row/rd_addr counter with wrap), is natural; the FSM and window-valid logic SHALL stay in the top block.

Verification
REQ-034 Bench: IMG_W=4, IMG_H=4, start pulse, win_ready=1 -> 16 pushes at rd_addr 0..15; win_valid after pushes 10, 11, 14, 15 with out_addr 0..3; done exactly 1 cycle after the last window.
REQ-035 Bench: same setup, win_ready=0 for 3 cycles when out_addr=1 -> rd_addr frozen at 12, push_pixel=0 for 3 cycles, total frame 3 cycles longer.
REQ-036 Bench: start held high for the whole frame -> exactly one frame and one done pulse per IDLE entry.
REQ-037 Bench: reset=0 at rd_addr=7 -> all outputs 0 asynchronously; a new start restarts at rd_addr=0 with out_addr=0.
REQ-038 Bench: IMG_W=3, IMG_H=3 -> single window with out_addr=0 after push 8.
REQ-039 Bench, with CONV_WINDOW_CTRL_ABORT_EN: abort at rd_addr=5 -> IDLE next cycle, done=1 for 1 cycle, no win_valid.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window controller.
package conv_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned IMG_W_DEF = 32;
    localparam int unsigned IMG_H_DEF = 32;

    // Number of fully in-image 3x3 windows in a w x h frame.
    function automatic int unsigned win_count(input int unsigned w, input int unsigned h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel-fetch and window handshake bundle between the window controller and its neighbours.
interface conv_window_ctrl_if #(
    parameter int unsigned ADDR_W = 11
);
    logic [ADDR_W-1:0] rd_addr;
    logic              push_pixel;
    logic              win_valid;
    logic              win_ready;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output rd_addr,
        output push_pixel,
        output win_valid,
        output out_addr,
        input  win_ready
    );

    modport slave (
        input  rd_addr,
        input  push_pixel,
        input  win_valid,
        input  out_addr,
        output win_ready
    );
endinterface

// File: rtl/conv_pos_counter.sv
// Raster-scan position counter: linear read address plus col/row with wrap at the image width.
module conv_pos_counter #(
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] col,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ColLast  = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(IMG_W * IMG_H - 1);

    logic [ADDR_W-1:0] col_q, row_q, addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (clear) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (advance) begin
            addr_q <= addr_q + 1'b1;
            if (col_q == ColLast) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = addr_q;
    assign last = (addr_q == AddrLast);

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for a 3x3 sliding-window convolution over an image register file.
// Optional abort input enabled by defining CONV_WINDOW_CTRL_ABORT_EN.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned ADDR_W = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
`ifdef CONV_WINDOW_CTRL_ABORT_EN
    input  logic abort,
`endif
    conv_window_ctrl_if.master win,
    output logic busy,
    output logic done
);

    localparam logic [ADDR_W-1:0] Two = ADDR_W'(2);

    logic [1:0]        rst_sync_q;
    logic              rst_int_n;
    state_e            state_q, state_d;
    logic              win_valid_q, win_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ADDR_W-1:0] win_idx_q, win_idx_d;
    logic [ADDR_W-1:0] col, row, addr;
    logic              last, push, stall, accept, frame_start, win_pos, abort_hit;

    // Assert asynchronously, release two clock edges after reset rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign frame_start = (state_q == StIdle) && start;
    assign accept      = win_valid_q && win.win_ready;
    assign stall       = win_valid_q && !win.win_ready;
    assign push        = (state_q == StRun) && !stall && !abort_hit;
    assign win_pos     = (row >= Two) && (col >= Two);

    conv_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) u_pos (
        .clk    (clk),
        .reset  (rst_int_n),
        .clear  (frame_start),
        .advance(push),
        .col    (col),
        .row    (row),
        .addr   (addr),
        .last   (last)
    );

    always_comb begin
        state_d     = state_q;
        win_valid_d = win_valid_q;
        out_addr_d  = out_addr_q;
        win_idx_d   = win_idx_q;

        if (frame_start) begin
            out_addr_d = '0;
            win_idx_d  = '0;
        end

        // A push replaces the presented window, so acceptance and push may coincide.
        if (push) begin
            win_valid_d = win_pos;
            if (win_pos) begin
                out_addr_d = win_idx_q;
                win_idx_d  = win_idx_q + 1'b1;
            end
        end else if (accept) begin
            win_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (push && last) state_d = StDrain;
            StDrain: if (!win_valid_q || accept) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort_hit) begin
            state_d     = StIdle;
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= StIdle;
            win_valid_q <= 1'b0;
            out_addr_q  <= '0;
            win_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            out_addr_q  <= out_addr_d;
            win_idx_q   <= win_idx_d;
        end
    end

`ifdef CONV_WINDOW_CTRL_ABORT_EN
    logic abort_done_q;

    assign abort_hit = abort && ((state_q == StRun) || (state_q == StDrain));

    // Abort ends the frame in IDLE, so its done pulse comes from a separate flop.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) abort_done_q <= 1'b0;
        else            abort_done_q <= abort_hit;
    end

    assign done = (state_q == StDone) || abort_done_q;
`else
    assign abort_hit = 1'b0;
    assign done      = (state_q == StDone);
`endif

    assign busy           = (state_q != StIdle);
    assign win.rd_addr    = addr;
    assign win.push_pixel = push;
    assign win.win_valid  = win_valid_q;
    assign win.out_addr   = out_addr_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl: 4x4 and 3x3 instances against a pixel-level model.
module tb_conv_window_ctrl;
    import conv_pkg::*;

    localparam int unsigned AW = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a, start_b, ready;
    logic busy_a, done_a, busy_b, done_b;
`ifdef CONV_WINDOW_CTRL_ABORT_EN
    logic abort;
`endif

    conv_window_ctrl_if #(.ADDR_W(AW)) if_a ();
    conv_window_ctrl_if #(.ADDR_W(AW)) if_b ();
    assign if_a.win_ready = ready;
    assign if_b.win_ready = ready;

    conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW)) dut_a (
        .clk  (clk),
        .reset(reset),
        .start(start_a),
`ifdef CONV_WINDOW_CTRL_ABORT_EN
        .abort(abort),
`endif
        .win  (if_a),
        .busy (busy_a),
        .done (done_a)
    );

    conv_window_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(AW)) dut_b (
        .clk  (clk),
        .reset(reset),
        .start(start_b),
`ifdef CONV_WINDOW_CTRL_ABORT_EN
        .abort(1'b0),
`endif
        .win  (if_b),
        .busy (busy_b),
        .done (done_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int sel = 0;
    string scen = "init";

    // Model: pixels pushed so far, presented window, frame phase flags.
    bit m_active, m_done, m_abort_done, m_wv;
    int m_pix, m_wa, m_w, m_h;

    logic [AW-1:0] o_rd, o_oa;
    logic o_push, o_wv, o_busy, o_done;

    int cyc, n_push, n_win, n_done, n_busy, n_frozen;
    int last_win_cyc, done_cyc, push8_cyc, win_cyc, abort_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", scen, tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (sel == 0) begin
            o_rd = if_a.rd_addr; o_oa = if_a.out_addr; o_push = if_a.push_pixel;
            o_wv = if_a.win_valid; o_busy = busy_a; o_done = done_a;
        end else begin
            o_rd = if_b.rd_addr; o_oa = if_b.out_addr; o_push = if_b.push_pixel;
            o_wv = if_b.win_valid; o_busy = busy_b; o_done = done_b;
        end
    endtask

    task automatic model_reset(input int w, input int h);
        m_active = 0; m_done = 0; m_abort_done = 0; m_wv = 0;
        m_pix = 0; m_wa = 0; m_w = w; m_h = h;
    endtask

    task automatic clear_stats();
        cyc = 0; n_push = 0; n_win = 0; n_done = 0; n_busy = 0; n_frozen = 0;
        last_win_cyc = -1; done_cyc = -1; push8_cyc = -1; win_cyc = -1; abort_cyc = -1;
    endtask

    task automatic check_zero(input string tag);
        sample();
        check({tag, ".rd_addr"}, o_rd, 0);
        check({tag, ".push"}, o_push, 0);
        check({tag, ".win_valid"}, o_wv, 0);
        check({tag, ".out_addr"}, o_oa, 0);
        check({tag, ".busy"}, o_busy, 0);
        check({tag, ".done"}, o_done, 0);
    endtask

    // One clock cycle: drive at negedge, check 1ns later, advance model, wait for next negedge.
    task automatic step(input bit st, input bit rdy, input bit ab);
        int n, p, r, c;
        bit stall, ab_hit, push_e, acc, was_ab;
        n = m_w * m_h;
        start_a = (sel == 0) ? st : 1'b0;
        start_b = (sel == 1) ? st : 1'b0;
        ready   = rdy;
`ifdef CONV_WINDOW_CTRL_ABORT_EN
        abort = ab;
`endif
        #1;
        sample();
        stall  = m_wv && !rdy;
        ab_hit = ab && m_active;
        push_e = m_active && (m_pix < n) && !stall && !ab_hit;
        acc    = m_wv && rdy;
        check("rd_addr", o_rd, m_pix[AW-1:0]);
        check("push_pixel", o_push, push_e);
        check("win_valid", o_wv, m_wv);
        check("out_addr", o_oa, m_wa[AW-1:0]);
        check("busy", o_busy, m_active || m_done);
        check("done", o_done, m_done || m_abort_done);

        if (o_push) n_push++;
        if (o_wv && rdy) begin n_win++; last_win_cyc = cyc; end
        if (o_done) begin n_done++; done_cyc = cyc; end
        if (o_busy) n_busy++;
        if (o_busy && !o_push && o_rd == 12) n_frozen++;
        if (o_push && o_rd == 8) push8_cyc = cyc;
        if (o_wv && win_cyc < 0) win_cyc = cyc;
        if (ab) abort_cyc = cyc;
        cyc++;

        was_ab = 0;
        if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (st) begin m_active = 1; m_pix = 0; m_wa = 0; m_wv = 0; end
        end else if (ab_hit) begin
            m_active = 0; m_wv = 0; was_ab = 1;
        end else if (m_pix == n) begin
            if (!m_wv || acc) begin m_active = 0; m_done = 1; m_wv = 0; end
        end else if (push_e) begin
            p = m_pix; m_pix++;
            r = p / m_w; c = p % m_w;
            if (r >= 2 && c >= 2) begin
                m_wv = 1;
                m_wa = (r - 2) * (m_w - 2) + (c - 2);
            end else begin
                m_wv = 0;
            end
        end
        m_abort_done = was_ab;
        @(negedge clk);
    endtask

    initial begin
        int stall_left, guard;
        bit r;
        start_a = 0; start_b = 0; ready = 0;
`ifdef CONV_WINDOW_CTRL_ABORT_EN
        abort = 0;
`endif
        model_reset(4, 4);
        clear_stats();
        #2 reset = 1'b0;
        @(negedge clk);
        scen = "reset";
        sel = 1; check_zero("b");
        sel = 0; check_zero("a");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) step(0, 1, 0);

        scen = "basic";
        clear_stats();
        step(1, 1, 0);
        for (int i = 0; i < 25; i++) step(0, 1, 0);
        check("n_push", n_push, 16);
        check("n_win", n_win, 4);
        check("n_busy", n_busy, 18);
        check("n_done", n_done, 1);
        check("done_after_last_win", done_cyc - last_win_cyc, 1);
        sample();
        check("final_out_addr", o_oa, win_count(4, 4) - 1);

        scen = "stall";
        clear_stats();
        stall_left = 3;
        for (int i = 0; i < 30; i++) begin
            r = !(m_wv && m_wa == 1 && stall_left > 0);
            if (!r) stall_left--;
            step(i == 0, r, 0);
        end
        check("n_busy", n_busy, 21);
        check("n_frozen", n_frozen, 3);
        check("n_win", n_win, 4);

        scen = "start_held";
        clear_stats();
        for (int i = 0; i < 57; i++) step(1, 1, 0);
        step(0, 1, 0);
        check("n_done", n_done, 3);
        check("n_busy", n_busy, 54);

        scen = "reset_mid";
        clear_stats();
        step(1, 1, 0);
        guard = 0;
        while (m_pix != 7 && guard < 20) begin step(0, 1, 0); guard++; end
        sample();
        check("rd_before_reset", o_rd, 7);
        #2 reset = 1'b0;
        #1 check_zero("async");
        model_reset(4, 4);
        repeat (2) @(negedge clk);
        check_zero("held");
        reset = 1'b1;
        repeat (3) step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 25; i++) step(0, 1, 0);
        check("n_done", n_done, 1);
        check("n_win", n_win, 4);

        scen = "random";
        for (int f = 0; f < 2; f++) begin
            clear_stats();
            repeat ($urandom_range(0, 3)) step(0, 1, 0);
            step(1, 1, 0);
            for (int i = 0; i < 80; i++) step(0, $urandom_range(0, 3) != 0, 0);
            check("n_push", n_push, 16);
            check("n_win", n_win, 4);
            check("n_done", n_done, 1);
        end

`ifdef CONV_WINDOW_CTRL_ABORT_EN
        scen = "abort";
        clear_stats();
        step(1, 1, 0);
        guard = 0;
        while (m_pix != 5 && guard < 20) begin step(0, 1, 0); guard++; end
        step(0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        check("n_done", n_done, 1);
        check("n_win", n_win, 0);
        check("done_after_abort", done_cyc - abort_cyc, 1);
`endif

        scen = "img3x3";
        sel = 1;
        model_reset(3, 3);
        clear_stats();
        step(1, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0);
        check("n_push", n_push, 9);
        check("n_win", n_win, 1);
        check("n_done", n_done, 1);
        check("win_after_push8", win_cyc - push8_cyc, 1);
        sample();
        check("final_out_addr", o_oa, win_count(3, 3) - 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at scenario %s", scen);
        $fatal(1, "watchdog expired");
    end

endmodule
